comp_mult_mem_arb: RTL and testbench

//  Two-requester arbiter sharing the single-port mem_1rw of comp_mult_top (1 access/cycle).

---
 rtl/comp_mult_pkg.sv | 14 +
 rtl/comp_mult_rr_arb2.sv | 48 ++++
 rtl/comp_mult_mem_arb.sv | 118 +++++++++++
 tb/tb_comp_mult_mem_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_mult_pkg.sv
// Shared constants for the comp_mult memory arbitration slice.
package comp_mult_pkg;

    // Arbitration mode selectors for the FIXED_PRIO parameter
    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Requester tags carried alongside a memory command
    typedef enum logic {
        REQ_OP  = 1'b0,   // operand fetch
        REQ_RES = 1'b1    // result writeback
    } req_tag_e;

endpackage

// File: rtl/comp_mult_rr_arb2.sv
// Two-way arbiter: combinational grant pick plus a last-grant pointer flop.
module comp_mult_rr_arb2
    import comp_mult_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = ARB_RR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_tag_e last_gnt;

    // Grant pick: lone requester wins; on contention fixed priority or the one not served last
    always_comb begin
        gnt = '0;
        if (rst_n && !sw_rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (FIXED_PRIO == ARB_FIXED || last_gnt == REQ_RES) begin
                        gnt = 2'b01;
                    end else begin
                        gnt = 2'b10;
                    end
                end
                default: gnt = '0;
            endcase
        end
    end

    // Pointer follows accepted commands only; resets so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= REQ_RES;
        end else if (sw_rst) begin
            last_gnt <= REQ_RES;
        end else if (gnt[0]) begin
            last_gnt <= REQ_OP;
        end else if (gnt[1]) begin
            last_gnt <= REQ_RES;
        end
    end

endmodule

// File: rtl/comp_mult_mem_arb.sv
// Two-requester arbiter in front of the single-port mem_1rw: registered command
// stage, tagged read-return pipeline and per-requester rvalid decode.
module comp_mult_mem_arb
    import comp_mult_pkg::*;
#(
    parameter int unsigned SYS_AW     = 16,
    parameter int unsigned MEM_DW     = 8,
    parameter int unsigned FIXED_PRIO = ARB_RR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_rst,
    input  logic              rq0_val,
    output logic              rq0_rdy,
    input  logic              rq0_we,
    input  logic [SYS_AW-1:0] rq0_addr,
    input  logic [MEM_DW-1:0] rq0_wdata,
    output logic              rq0_rvalid,
    input  logic              rq1_val,
    output logic              rq1_rdy,
    input  logic              rq1_we,
    input  logic [SYS_AW-1:0] rq1_addr,
    input  logic [MEM_DW-1:0] rq1_wdata,
    output logic              rq1_rvalid,
    output logic [MEM_DW-1:0] rd_data,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [SYS_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wr_data,
    input  logic [MEM_DW-1:0] mem_rd_data
);

    logic [1:0]        gnt;
    logic              acc;
    logic              sel_we;
    logic [SYS_AW-1:0] sel_addr;
    logic [MEM_DW-1:0] sel_wdata;
    req_tag_e          cmd_tag;
    req_tag_e          rd_tag;
    logic              rd_pend;

    comp_mult_rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_rst(sw_rst),
        .req   ({rq1_val, rq0_val}),
        .gnt   (gnt)
    );

    assign rq0_rdy = gnt[0];
    assign rq1_rdy = gnt[1];
    assign acc     = |gnt;

    // Command mux: route the granted requester's fields to the command register
    always_comb begin
        sel_we    = rq0_we;
        sel_addr  = rq0_addr;
        sel_wdata = rq0_wdata;
        if (gnt[1]) begin
            sel_we    = rq1_we;
            sel_addr  = rq1_addr;
            sel_wdata = rq1_wdata;
        end
    end

    // Command register: one-cycle strobe per accept; address/data hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cmd_tag     <= REQ_OP;
        end else if (sw_rst) begin
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cmd_tag     <= REQ_OP;
        end else begin
            mem_ce <= acc;
            mem_we <= acc && sel_we;
            if (acc) begin
                mem_addr    <= sel_addr;
                mem_wr_data <= sel_wdata;
                cmd_tag     <= gnt[1] ? REQ_RES : REQ_OP;
            end
        end
    end

    // Read return: tag follows the access into the data cycle, then decodes to rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            rd_tag     <= REQ_OP;
            rq0_rvalid <= 1'b0;
            rq1_rvalid <= 1'b0;
            rd_data    <= '0;
        end else if (sw_rst) begin
            rd_pend    <= 1'b0;
            rd_tag     <= REQ_OP;
            rq0_rvalid <= 1'b0;
            rq1_rvalid <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_pend    <= mem_ce && !mem_we;
            rd_tag     <= cmd_tag;
            rq0_rvalid <= rd_pend && (rd_tag == REQ_OP);
            rq1_rvalid <= rd_pend && (rd_tag == REQ_RES);
            if (rd_pend) begin
                rd_data <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_comp_mult_mem_arb.sv
// Directed bench for comp_mult_mem_arb with a behavioural single-port memory.
`timescale 1ns/1ps
module tb_comp_mult_mem_arb;

    logic        clk;
    logic        rst_n;
    logic        sw_rst;
    logic        rq0_val, rq0_we, rq1_val, rq1_we;
    logic [15:0] rq0_addr, rq1_addr;
    logic [7:0]  rq0_wdata, rq1_wdata;
    logic        rq0_rdy, rq1_rdy, rq0_rvalid, rq1_rvalid;
    logic [7:0]  rd_data;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data, mem_rd_data;

    logic        f_rq0_rdy, f_rq1_rdy, f_rq0_rvalid, f_rq1_rvalid;
    logic [7:0]  f_rd_data, f_mem_wr_data;
    logic        f_mem_ce, f_mem_we;
    logic [15:0] f_mem_addr;

    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem [0:65535];

    int unsigned n_vec;
    int unsigned n_err;

    comp_mult_mem_arb #(.SYS_AW(16), .MEM_DW(8), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
        .rq0_val(rq0_val), .rq0_rdy(rq0_rdy), .rq0_we(rq0_we), .rq0_addr(rq0_addr),
        .rq0_wdata(rq0_wdata), .rq0_rvalid(rq0_rvalid),
        .rq1_val(rq1_val), .rq1_rdy(rq1_rdy), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
        .rq1_wdata(rq1_wdata), .rq1_rvalid(rq1_rvalid),
        .rd_data(rd_data), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    comp_mult_mem_arb #(.SYS_AW(16), .MEM_DW(8), .FIXED_PRIO(1)) dut_fix (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
        .rq0_val(rq0_val), .rq0_rdy(f_rq0_rdy), .rq0_we(rq0_we), .rq0_addr(rq0_addr),
        .rq0_wdata(rq0_wdata), .rq0_rvalid(f_rq0_rvalid),
        .rq1_val(rq1_val), .rq1_rdy(f_rq1_rdy), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
        .rq1_wdata(rq1_wdata), .rq1_rvalid(f_rq1_rvalid),
        .rd_data(f_rd_data), .mem_ce(f_mem_ce), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
        .mem_wr_data(f_mem_wr_data), .mem_rd_data(8'h00)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: write on ce&we, registered read data the cycle after the access
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_ce && mem_we) begin
            mem[mem_addr] <= mem_wr_data;
        end
        if (mem_ce && !mem_we) begin
            mem_rd_data <= mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] sdat(input int unsigned i);
        sdat = 8'((i * 7 + 3) & 255);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    // rq0 read of address 500, expecting 8'h3C two cycles after accept
    task automatic single_read(input string p);
        rq0_val = 1'b1; rq0_we = 1'b0; rq0_addr = 16'd500;
        #1;
        chk({p, "_rdy0"}, rq0_rdy, 1);
        chk({p, "_rdy1"}, rq1_rdy, 0);
        tick();
        rq0_val = 1'b0;
        chk({p, "_ce"}, mem_ce, 1);
        chk({p, "_we"}, mem_we, 0);
        chk({p, "_addr"}, mem_addr, 500);
        chk({p, "_rv0_e0"}, rq0_rvalid, 0);
        tick();
        chk({p, "_ce_off"}, mem_ce, 0);
        chk({p, "_rv0_e1"}, rq0_rvalid, 0);
        tick();
        chk({p, "_rv0"}, rq0_rvalid, 1);
        chk({p, "_data"}, rd_data, 8'h3C);
        chk({p, "_rv1"}, rq1_rvalid, 0);
        tick();
        chk({p, "_rv0_end"}, rq0_rvalid, 0);
    endtask

    initial begin
        int unsigned acc, nrv, bad;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; sw_rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        rq0_val = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0;
        rq1_val = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;
        tick();
        preload(16'd500, 8'h3C);
        preload(16'd4500, 8'h11);
        for (int i = 0; i < 300; i++) preload(16'(1500 + i), sdat(i));

        // Reset state, requests present but rdy held low
        rq0_val = 1'b1; rq1_val = 1'b1;
        #1;
        chk("rst_rdy0", rq0_rdy, 0);
        chk("rst_rdy1", rq1_rdy, 0);
        chk("rst_ce", mem_ce, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wr_data, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rv0", rq0_rvalid, 0);
        chk("rst_rv1", rq1_rvalid, 0);
        rq0_val = 1'b0; rq1_val = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single read
        single_read("t1");

        // RAW: last grant was 0, so rq1 write wins the tie
        rq1_val = 1'b1; rq1_we = 1'b1; rq1_addr = 16'd4500; rq1_wdata = 8'hA5;
        rq0_val = 1'b1; rq0_we = 1'b0; rq0_addr = 16'd4500;
        #1;
        chk("raw_gnt1", rq1_rdy, 1);
        chk("raw_nogn0", rq0_rdy, 0);
        tick();
        rq1_val = 1'b0; rq1_we = 1'b0;
        #1;
        chk("raw_w_ce", mem_ce, 1);
        chk("raw_w_we", mem_we, 1);
        chk("raw_w_addr", mem_addr, 4500);
        chk("raw_w_data", mem_wr_data, 8'hA5);
        chk("raw_gnt0", rq0_rdy, 1);
        tick();
        rq0_val = 1'b0;
        chk("raw_r_ce", mem_ce, 1);
        chk("raw_r_we", mem_we, 0);
        tick();
        chk("raw_w_no_rv1", rq1_rvalid, 0);
        tick();
        chk("raw_rv0", rq0_rvalid, 1);
        chk("raw_data", rd_data, 8'hA5);
        chk("raw_rv1", rq1_rvalid, 0);
        tick();

        // sw_rst forces rdy low and re-arms the pointer; then round-robin contention
        sw_rst = 1'b1;
        rq0_val = 1'b1; rq0_addr = 16'd10; rq1_val = 1'b1; rq1_addr = 16'd20;
        #1;
        chk("swr_rdy0", rq0_rdy, 0);
        chk("swr_rdy1", rq1_rdy, 0);
        tick();
        sw_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_rdy0", rq0_rdy, (i % 2 == 0) ? 1 : 0);
            chk("rr_rdy1", rq1_rdy, (i % 2 == 1) ? 1 : 0);
            chk("fix_rdy0", f_rq0_rdy, 1);
            chk("fix_rdy1", f_rq1_rdy, 0);
            tick();
        end
        rq0_val = 1'b0; rq1_val = 1'b0;
        tick(); tick(); tick();

        // Streaming 300 reads from rq0
        acc = 0; nrv = 0; bad = 0;
        for (int c = 0; c < 304; c++) begin
            if (c < 300) begin
                rq0_val = 1'b1; rq0_addr = 16'(1500 + c);
            end else begin
                rq0_val = 1'b0;
            end
            #1;
            if (c < 300 && rq0_rdy) acc++;
            if (rq0_rvalid) begin
                chk("stream_data", rd_data, sdat(nrv));
                nrv++;
            end
            if (rq1_rvalid) bad++;
            tick();
        end
        chk("stream_accepts", acc, 300);
        chk("stream_rvalids", nrv, 300);
        chk("stream_rv1", bad, 0);

        // sw_rst one cycle after a read accept drops the read
        rq0_val = 1'b1; rq0_addr = 16'd500;
        #1;
        chk("swf_rdy0", rq0_rdy, 1);
        tick();
        rq0_val = 1'b0; sw_rst = 1'b1;
        chk("swf_ce", mem_ce, 1);
        tick();
        sw_rst = 1'b0;
        chk("swf_ce_off", mem_ce, 0);
        chk("swf_addr", mem_addr, 0);
        chk("swf_rv0_a", rq0_rvalid, 0);
        tick();
        chk("swf_rv0_b", rq0_rvalid, 0);
        tick();
        chk("swf_rv0_c", rq0_rvalid, 0);
        rq0_val = 1'b1; rq1_val = 1'b1;
        #1;
        chk("swf_tie_rdy0", rq0_rdy, 1);
        chk("swf_tie_rdy1", rq1_rdy, 0);
        tick();
        rq0_val = 1'b0; rq1_val = 1'b0;
        tick(); tick(); tick();

        // Async reset in the middle of a stream
        rq0_val = 1'b1; rq0_addr = 16'd1500;
        tick(); rq0_addr = 16'd1501;
        tick(); rq0_addr = 16'd1502;
        tick(); rq0_addr = 16'd1503;
        #1;
        chk("mid_rv0", rq0_rvalid, 1);
        chk("mid_data", rd_data, sdat(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rdy0", rq0_rdy, 0);
        chk("arst_ce", mem_ce, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_rv0", rq0_rvalid, 0);
        chk("arst_rd_data", rd_data, 0);
        rq0_val = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        single_read("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
